// File: rtl/keccak_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : keccak_round_sequencer
// Purpose  : Round sequencer for the low-throughput SHA-3 core. Accepts a
//            permutation request and walks ROUNDS Keccak-f rounds, one per
//            cycle, stalling on pause. Produces a registered one-hot round
//            index for the round constant generator, a registered binary
//            round number, and round-enable / completion handshakes.
// Ports    : clk          - rising-edge clock
//            reset        - synchronous active-low reset
//            start        - permutation request (taken when start & in_ready)
//            in_ready     - sequencer can accept start this cycle
//            pause        - stall; holds the current round while in RUN
//            round_onehot - one-hot current round, zero when no round active
//            round_num    - binary current round, zero when idle
//            round_en     - datapath applies round round_num this cycle
//            first_round  - RUN and round 0 (datapath loads absorbed block)
//            last_round   - RUN and round ROUNDS-1
//            out_valid    - permutation complete, held until out_ack
//            out_ack      - consumer accepts the result
// Revision : 1.0 - initial release
// ============================================================================
module keccak_round_sequencer #(
    parameter int ROUNDS  = 24,
    parameter int ROUND_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                in_ready,
    input  logic                pause,
    output logic [ROUNDS-1:0]   round_onehot,
    output logic [ROUND_W-1:0]  round_num,
    output logic                round_en,
    output logic                first_round,
    output logic                last_round,
    output logic                out_valid,
    input  logic                out_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [ROUND_W-1:0] c_last_round  = ROUND_W'(ROUNDS - 1);
    localparam logic [ROUNDS-1:0]  c_onehot_zero = '0;
    localparam logic [ROUNDS-1:0]  c_onehot_r0   = ROUNDS'(1);

    state_t             r_state;
    logic [ROUNDS-1:0]  r_onehot;
    logic [ROUND_W-1:0] r_num;
    logic               r_out_valid;

    logic               w_run;
    logic               w_at_last;

    assign w_run     = (r_state == ST_RUN);
    assign w_at_last = (r_num == c_last_round);

    // The HOLD-with-ack term lets a new request be taken in the same cycle the
    // previous result is consumed, so back-to-back permutations have no bubble.
    assign in_ready     = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & out_ack);
    assign round_en     = w_run & ~pause;
    assign first_round  = w_run & (r_num == '0);
    assign last_round   = w_run & w_at_last;
    assign round_onehot = r_onehot;
    assign round_num    = r_num;
    assign out_valid    = r_out_valid;

    // Index registers are updated directly (not decoded from a counter) so the
    // constant lookup sees a flop output with no decode depth in front of it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_onehot    <= c_onehot_zero;
            r_num       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_onehot <= c_onehot_r0;
                        r_num    <= '0;
                    end
                end
                ST_RUN: begin
                    if (!pause) begin
                        if (w_at_last) begin
                            r_state     <= ST_HOLD;
                            r_onehot    <= c_onehot_zero;
                            r_num       <= '0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_onehot <= r_onehot << 1;
                            r_num    <= r_num + ROUND_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ack) begin
                        r_out_valid <= 1'b0;
                        if (start) begin
                            r_state  <= ST_RUN;
                            r_onehot <= c_onehot_r0;
                            r_num    <= '0;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    // Unused encoding: return to a clean idle state.
                    r_state     <= ST_IDLE;
                    r_onehot    <= c_onehot_zero;
                    r_num       <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_keccak_round_sequencer
// Purpose  : Self-checking bench for keccak_round_sequencer. A short vector
//            table covers reset, idle, pause-in-idle, ignored start/ack and a
//            reset abort; hand-written sequences cover full runs, stalls,
//            HOLD behaviour, back-to-back requests, abort recovery and the
//            round constants selected by the one-hot index.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keccak_round_sequencer;

    localparam int ROUNDS  = 24;
    localparam int ROUND_W = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               pause;
    logic               out_ack;
    logic               in_ready;
    logic [ROUNDS-1:0]  round_onehot;
    logic [ROUND_W-1:0] round_num;
    logic               round_en;
    logic               first_round;
    logic               last_round;
    logic               out_valid;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    keccak_round_sequencer #(
        .ROUNDS  (ROUNDS),
        .ROUND_W (ROUND_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_ready     (in_ready),
        .pause        (pause),
        .round_onehot (round_onehot),
        .round_num    (round_num),
        .round_en     (round_en),
        .first_round  (first_round),
        .last_round   (last_round),
        .out_valid    (out_valid),
        .out_ack      (out_ack)
    );

    typedef struct {
        bit                 rst_n;
        bit                 st;
        bit                 pz;
        bit                 ack;
        bit                 e_ready;
        bit                 e_en;
        bit                 e_first;
        bit                 e_last;
        bit                 e_valid;
        logic [ROUNDS-1:0]  e_onehot;
        logic [ROUND_W-1:0] e_num;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Round constant generator model driven by the one-hot index: the
    // constants come from the Keccak LFSR (x^8+x^6+x^5+x^4+1).
    function automatic logic lfsr_bit(input int t);
        logic [8:0] r;
        r = 9'h001;
        for (int i = 0; i < (t % 255); i++) begin
            r = r << 1;
            if (r[8]) r = r ^ 9'h171;
        end
        return r[0];
    endfunction

    function automatic logic [63:0] rc_from_onehot(input logic [ROUNDS-1:0] oh);
        logic [63:0] rc;
        int idx;
        int cnt;
        rc  = '0;
        idx = 0;
        cnt = 0;
        for (int i = 0; i < ROUNDS; i++) begin
            if (oh[i]) begin
                idx = i;
                cnt++;
            end
        end
        if (cnt == 1) begin
            for (int j = 0; j < 7; j++) rc[(1 << j) - 1] = lfsr_bit(j + 7 * idx);
        end
        return rc;
    endfunction

    task automatic chk_outs(input string tag, input vec_t v);
        chk({tag, ".in_ready"},    64'(in_ready),     64'(v.e_ready));
        chk({tag, ".round_en"},    64'(round_en),     64'(v.e_en));
        chk({tag, ".first_round"}, 64'(first_round),  64'(v.e_first));
        chk({tag, ".last_round"},  64'(last_round),   64'(v.e_last));
        chk({tag, ".out_valid"},   64'(out_valid),    64'(v.e_valid));
        chk({tag, ".onehot"},      64'(round_onehot), 64'(v.e_onehot));
        chk({tag, ".round_num"},   64'(round_num),    64'(v.e_num));
    endtask

    // Entered during the first RUN cycle (just after the accepting edge).
    // Stalls 3 cycles before rounds pa and pb; leaves the bench in the first
    // HOLD cycle.
    task automatic run_perm(input string tag, input int pa, input int pb, input bit do_rc);
        logic [ROUNDS-1:0] one;
        logic [ROUNDS-1:0] exp_oh;
        int en_cnt;
        int cyc;
        int stalls;
        one    = ROUNDS'(1);
        en_cnt = 0;
        cyc    = 0;
        stalls = 0;
        for (int k = 0; k < ROUNDS; k++) begin
            exp_oh = one << k;
            if (k == pa || k == pb) begin
                for (int p = 0; p < 3; p++) begin
                    start = 1'b0; pause = 1'b1; out_ack = 1'b0;
                    #1;
                    chk({tag, ".stall_onehot"}, 64'(round_onehot), 64'(exp_oh));
                    chk({tag, ".stall_num"},    64'(round_num),    64'(k));
                    chk({tag, ".stall_en"},     64'(round_en),     64'(0));
                    if (round_en) en_cnt++;
                    cyc++;
                    stalls++;
                    @(negedge clk);
                end
            end
            pause   = 1'b0;
            start   = (k == 7);   // must be ignored mid-run
            out_ack = (k == 9);   // must be ignored outside HOLD
            #1;
            if (round_onehot !== exp_oh || round_num !== ROUND_W'(k) || round_en !== 1'b1 ||
                first_round !== (k == 0) || last_round !== (k == ROUNDS - 1) ||
                in_ready !== 1'b0 || out_valid !== 1'b0) begin
                checks++;
                $display("FAIL %s.round%0d: got oh=%h num=%0d en=%b first=%b last=%b rdy=%b ov=%b required oh=%h num=%0d en=1 first=%b last=%b rdy=0 ov=0",
                         tag, k, round_onehot, round_num, round_en, first_round, last_round,
                         in_ready, out_valid, exp_oh, k, (k == 0), (k == ROUNDS - 1));
            end else begin
                checks++;
                passed++;
            end
            if (do_rc) begin
                if (k == 0)  chk({tag, ".rc0"},  rc_from_onehot(round_onehot), 64'h0000000000000001);
                if (k == 1)  chk({tag, ".rc1"},  rc_from_onehot(round_onehot), 64'h0000000000008082);
                if (k == 23) chk({tag, ".rc23"}, rc_from_onehot(round_onehot), 64'h8000000080008008);
            end
            if (round_en) en_cnt++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; pause = 1'b0; out_ack = 1'b0;
        #1;
        chk({tag, ".en_cycles"},   64'(en_cnt), 64'(ROUNDS));
        chk({tag, ".run_length"},  64'(cyc),    64'(ROUNDS + stalls));
        chk({tag, ".hold_valid"},  64'(out_valid),    64'(1));
        chk({tag, ".hold_onehot"}, 64'(round_onehot), 64'(0));
        chk({tag, ".hold_num"},    64'(round_num),    64'(0));
        chk({tag, ".hold_en"},     64'(round_en),     64'(0));
        chk({tag, ".hold_ready"},  64'(in_ready),     64'(0));
    endtask

    task automatic ack_to_idle(input string tag);
        out_ack = 1'b1; start = 1'b0;
        #1;
        chk({tag, ".ack_ready"}, 64'(in_ready), 64'(1));
        @(negedge clk);
        out_ack = 1'b0;
        #1;
        chk({tag, ".idle_valid"}, 64'(out_valid), 64'(0));
        chk({tag, ".idle_ready"}, 64'(in_ready),  64'(1));
    endtask

    vec_t vecs[7];
    int   ov_seen;

    initial begin
        //          rst st pz ack | rdy en fst lst ov  onehot      num
        vecs[0] = '{1, 0, 0, 0,    1,  0,  0,  0,  0, 24'h000000, 5'd0};  // idle after reset
        vecs[1] = '{1, 1, 1, 0,    1,  0,  0,  0,  0, 24'h000000, 5'd0};  // pause in idle: start still taken
        vecs[2] = '{1, 0, 1, 0,    0,  0,  1,  0,  0, 24'h000001, 5'd0};  // round 0 stalled
        vecs[3] = '{1, 1, 0, 0,    0,  1,  1,  0,  0, 24'h000001, 5'd0};  // start ignored in RUN
        vecs[4] = '{1, 0, 0, 1,    0,  1,  0,  0,  0, 24'h000002, 5'd1};  // ack ignored in RUN
        vecs[5] = '{0, 0, 0, 0,    0,  1,  0,  0,  0, 24'h000004, 5'd2};  // reset applied at round 2
        vecs[6] = '{1, 0, 0, 0,    1,  0,  0,  0,  0, 24'h000000, 5'd0};  // aborted -> idle, no valid

        reset = 1'b0; start = 1'b0; pause = 1'b0; out_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            reset   = vecs[i].rst_n;
            start   = vecs[i].st;
            pause   = vecs[i].pz;
            out_ack = vecs[i].ack;
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i]);
            @(negedge clk);
        end
        reset = 1'b1; start = 1'b0; pause = 1'b0; out_ack = 1'b0;

        // Run 1: no stalls, round constants checked, then 10 cycles in HOLD.
        start = 1'b1;
        #1;
        chk("run1.accept_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        start = 1'b0;
        run_perm("run1", -1, -1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            out_ack = 1'b0; start = (i % 2 == 0); pause = (i == 3);
            #1;
            chk($sformatf("hold%0d.valid", i),  64'(out_valid),    64'(1));
            chk($sformatf("hold%0d.ready", i),  64'(in_ready),     64'(0));
            chk($sformatf("hold%0d.onehot", i), 64'(round_onehot), 64'(0));
            @(negedge clk);
        end
        pause = 1'b0;
        ack_to_idle("run1");

        // Run 2: stalls at rounds 5 and 23, ends with a back-to-back request.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_perm("run2", 5, 23, 1'b0);
        out_ack = 1'b1; start = 1'b1;
        #1;
        chk("b2b.ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        out_ack = 1'b0; start = 1'b0;
        #1;
        chk("b2b.onehot", 64'(round_onehot), 64'(1));
        chk("b2b.valid",  64'(out_valid),    64'(0));
        run_perm("run3", -1, -1, 1'b0);
        ack_to_idle("run3");

        // Run 4: reset at round 12 aborts; no completion may follow.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        chk("abort.num_before", 64'(round_num), 64'(12));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort.onehot", 64'(round_onehot), 64'(0));
        chk("abort.num",    64'(round_num),    64'(0));
        chk("abort.ready",  64'(in_ready),     64'(1));
        ov_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (out_valid !== 1'b0 || round_en !== 1'b0) ov_seen++;
        end
        chk("abort.no_valid", 64'(ov_seen), 64'(0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_perm("run5", -1, -1, 1'b1);
        ack_to_idle("run5");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
